// File: rtl/alu_result_buffer_if.sv
// ALU-to-writeback result channel: push side from the ALU, pop side to writeback.
// The buffer takes the slave modport; producer/consumer logic takes master.
interface alu_result_buffer_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_Z;
  logic [3:0]       IN_FLAGS;
  logic [TAGW-1:0]  IN_TAG;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_Z;
  logic [3:0]       OUT_FLAGS;
  logic [TAGW-1:0]  OUT_TAG;

  modport master (
    output IN_VALID, IN_Z, IN_FLAGS, IN_TAG, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_Z, OUT_FLAGS, OUT_TAG
  );

  modport slave (
    input  IN_VALID, IN_Z, IN_FLAGS, IN_TAG, OUT_READY,
    output IN_READY, OUT_VALID, OUT_Z, OUT_FLAGS, OUT_TAG
  );
endinterface

// File: rtl/alu_result_buffer.sv
// ALU result FIFO with registered head and sticky status flags.
// Optional FLAG_CHECK_EN adds FLAG_ERR (stored zero flag vs. Z mismatch).
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic                       CLOCK,
  input  logic                       RESET_N,
  alu_result_buffer_if.slave         bus,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic [3:0]                 STICKY,
  input  logic                       CLEAR_STICKY
`ifdef FLAG_CHECK_EN
  ,
  output logic                       FLAG_ERR
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic [3:0]       flags;
    logic [TAGW-1:0]  tag;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head_q, head_d;
  entry_t          in_entry;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      sticky_q, sticky_d;
  logic            full, empty, push, pop;

  assign in_entry = '{z: bus.IN_Z, flags: bus.IN_FLAGS, tag: bus.IN_TAG};
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.IN_VALID & ~full;
  assign pop      = bus.OUT_READY & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    // Next head: a surviving stored entry, else the incoming one, else hold.
    head_d = head_q;
    if ((count_q - CW'(pop)) != '0)
      head_d = mem_q[rd_ptr_d];
    else if (push)
      head_d = in_entry;
    sticky_d = CLEAR_STICKY ? 3'b000 : sticky_q;
    if (push)
      sticky_d = sticky_d | bus.IN_FLAGS[2:0];
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      sticky_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET_N && push)
      mem_q[wr_ptr_q] <= in_entry;
  end

`ifdef FLAG_CHECK_EN
  logic flag_err_q, flag_err_d;
  logic flag_chk;

  assign flag_chk = (bus.IN_FLAGS[2] != ~|bus.IN_Z);

  always_comb begin
    flag_err_d = CLEAR_STICKY ? 1'b0 : flag_err_q;
    if (push)
      flag_err_d = flag_err_d | flag_chk;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N)
      flag_err_q <= 1'b0;
    else
      flag_err_q <= flag_err_d;
  end

  assign FLAG_ERR = flag_err_q;
`endif

  assign bus.IN_READY  = ~full;
  assign bus.OUT_VALID = ~empty;
  assign bus.OUT_Z     = head_q.z;
  assign bus.OUT_FLAGS = head_q.flags;
  assign bus.OUT_TAG   = head_q.tag;
  assign COUNT         = count_q;
  assign STICKY        = {1'b0, sticky_q};
endmodule
